// File: rtl/voq_scheduler.sv
// Slot-based 4x4 crossbar scheduler: snapshots VOQ occupancy, builds a round-robin matching, issues dequeue strobes.
// Optional per-egress grant counters are built when SCHED_STATS_EN is defined.
module voq_scheduler #(
  parameter int unsigned PORT_CNT    = 4,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned SLOT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            experimenting,
  input  logic [PORT_CNT*PORT_CNT-1:0]    is_empty,
  output logic [PORT_CNT-1:0]             sched_en,
  output logic [PORT_CNT*SEL_WIDTH-1:0]   sched_sel,
  output logic [PORT_CNT*SEL_WIDTH-1:0]   xbar_sel,
  output logic [PORT_CNT-1:0]             xbar_valid,
  output logic                            busy
`ifdef SCHED_STATS_EN
  ,
  output logic [PORT_CNT*16-1:0]          grant_cnt
`endif
);

  localparam int unsigned CNT_WIDTH  = $clog2(SLOT_CYCLES);
  localparam int unsigned STAT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNAP  = 3'd1,
    MATCH = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t                               state;
  state_t                               state_nxt;
  logic [CNT_WIDTH-1:0]                 slot_cnt;
  logic [SEL_WIDTH-1:0]                 egr;
  logic [PORT_CNT-1:0][PORT_CNT-1:0]    req;      // req[egress][ingress]
  logic [PORT_CNT-1:0]                  matched;
  logic [PORT_CNT-1:0][SEL_WIDTH-1:0]   ptr;
  logic [PORT_CNT-1:0][SEL_WIDTH-1:0]   gnt_sel;
  logic [PORT_CNT-1:0]                  gnt_vld;

  logic [PORT_CNT-1:0]                  cand;
  logic                                 gnt_hit;
  logic [SEL_WIDTH-1:0]                 gnt_idx;
  logic [SEL_WIDTH-1:0]                 scan_idx;

  // Round-robin arbiter for the egress currently being matched
  always_comb begin
    cand     = req[egr] & ~matched;
    gnt_hit  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < PORT_CNT; k++) begin
      scan_idx = ptr[egr] + SEL_WIDTH'(k);
      if (!gnt_hit && cand[scan_idx]) begin
        gnt_hit = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (!experimenting) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (slot_cnt == '0) state_nxt = SNAP;
        SNAP:    state_nxt = MATCH;
        MATCH:   if (egr == SEL_WIDTH'(PORT_CNT - 1)) state_nxt = ISSUE;
        ISSUE:   state_nxt = WAIT;
        WAIT:    if (slot_cnt == CNT_WIDTH'(SLOT_CYCLES - 1)) state_nxt = SNAP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      egr        <= '0;
      req        <= '0;
      matched    <= '0;
      ptr        <= '0;
      gnt_sel    <= '0;
      gnt_vld    <= '0;
      sched_en   <= '0;
      sched_sel  <= '0;
      xbar_sel   <= '0;
      xbar_valid <= '0;
      busy       <= 1'b0;
    end else begin
      sched_en <= '0;
      busy     <= (state_nxt == SNAP) || (state_nxt == MATCH) || (state_nxt == ISSUE);

      if (!experimenting) begin
        slot_cnt   <= '0;
        xbar_valid <= '0;
      end else if (state == IDLE || slot_cnt == CNT_WIDTH'(SLOT_CYCLES - 1)) begin
        slot_cnt <= '0;
      end else begin
        slot_cnt <= slot_cnt + CNT_WIDTH'(1);
      end

      if (experimenting) begin
        case (state)
          SNAP: begin
            for (int e = 0; e < PORT_CNT; e++) begin
              for (int i = 0; i < PORT_CNT; i++) begin
                req[e][i] <= ~is_empty[i*PORT_CNT + e];
              end
            end
            matched <= '0;
            egr     <= '0;
            gnt_sel <= '0;
            gnt_vld <= '0;
          end
          MATCH: begin
            egr          <= egr + SEL_WIDTH'(1);
            gnt_vld[egr] <= gnt_hit;
            gnt_sel[egr] <= gnt_idx;
            if (gnt_hit) begin
              matched[gnt_idx] <= 1'b1;
              ptr[egr]         <= gnt_idx + SEL_WIDTH'(1);
            end
          end
          ISSUE: begin
            // Invert the egress->ingress matching into per-ingress strobes
            for (int i = 0; i < PORT_CNT; i++) begin
              sched_sel[i*SEL_WIDTH +: SEL_WIDTH] <= '0;
              for (int e = 0; e < PORT_CNT; e++) begin
                if (gnt_vld[e] && gnt_sel[e] == SEL_WIDTH'(i)) begin
                  sched_en[i]                         <= 1'b1;
                  sched_sel[i*SEL_WIDTH +: SEL_WIDTH] <= SEL_WIDTH'(e);
                end
              end
            end
            xbar_sel   <= gnt_sel;
            xbar_valid <= gnt_vld;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic exp_q;

  // Saturating per-egress grant counters, cleared when a run starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q     <= 1'b0;
      grant_cnt <= '0;
    end else begin
      exp_q <= experimenting;
      if (experimenting && !exp_q) begin
        grant_cnt <= '0;
      end else if (experimenting && state == ISSUE) begin
        for (int e = 0; e < PORT_CNT; e++) begin
          if (gnt_vld[e] && grant_cnt[e*STAT_WIDTH +: STAT_WIDTH] != 16'hFFFF) begin
            grant_cnt[e*STAT_WIDTH +: STAT_WIDTH] <=
              grant_cnt[e*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_voq_scheduler.sv
// Directed bench for voq_scheduler: per-slot vector table plus reset, latency, run-enable and stats sequences.
module tb_voq_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        experimenting;
  logic [15:0] is_empty;
  logic [3:0]  sched_en;
  logic [7:0]  sched_sel;
  logic [7:0]  xbar_sel;
  logic [3:0]  xbar_valid;
  logic        busy;
`ifdef SCHED_STATS_EN
  logic [63:0] grant_cnt;
`endif

  voq_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .experimenting (experimenting),
    .is_empty      (is_empty),
    .sched_en      (sched_en),
    .sched_sel     (sched_sel),
    .xbar_sel      (xbar_sel),
    .xbar_valid    (xbar_valid),
    .busy          (busy)
`ifdef SCHED_STATS_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] empty;
    logic [3:0]  en;
    logic [7:0]  ssel;
    logic [7:0]  xsel;
    logic [3:0]  xval;
  } vec_t;

  vec_t tbl [12];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count edges until the first dequeue strobe, bounded
  task automatic wait_en(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (sched_en == 4'h0 && n < 40);
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] en, input logic [7:0] ssel,
                          input logic [7:0] xsel, input logic [3:0] xval);
    chk({tag, ".sched_en"},   64'(sched_en),   64'(en));
    chk({tag, ".sched_sel"},  64'(sched_sel),  64'(ssel));
    chk({tag, ".xbar_sel"},   64'(xbar_sel),   64'(xsel));
    chk({tag, ".xbar_valid"}, 64'(xbar_valid), 64'(xval));
  endtask

  initial begin
    int          lat;
    logic [3:0]  prev_val;

    // Pointer state carries from row to row; rows start after one identity slot
    tbl[0]  = '{16'h0000, 4'hF, 8'h93, 8'h39, 4'hF};
    tbl[1]  = '{16'h0000, 4'hF, 8'h4E, 8'h4E, 4'hF};
    tbl[2]  = '{16'h0000, 4'hF, 8'h39, 8'h93, 4'hF};
    tbl[3]  = '{16'hFFFB, 4'h1, 8'h02, 8'h00, 4'h4};
    tbl[4]  = '{16'hFFFB, 4'h1, 8'h02, 8'h00, 4'h4};
    tbl[5]  = '{16'hDDDD, 4'h2, 8'h04, 8'h04, 4'h2};
    tbl[6]  = '{16'hDDDD, 4'h4, 8'h10, 8'h08, 4'h2};
    tbl[7]  = '{16'hDDDD, 4'h8, 8'h40, 8'h0C, 4'h2};
    tbl[8]  = '{16'hDDDD, 4'h1, 8'h01, 8'h00, 4'h2};
    tbl[9]  = '{16'hFFFF, 4'h0, 8'h00, 8'h00, 4'h0};
    tbl[10] = '{16'hF5EC, 4'h5, 8'h10, 8'h08, 4'h3};
    tbl[11] = '{16'hF5EC, 4'h7, 8'h31, 8'h81, 4'hB};

    reset         = 1'b0;
    experimenting = 1'b0;
    is_empty      = 16'hFFFF;
    step(2);
    chk_slot("reset", 4'h0, 8'h00, 8'h00, 4'h0);
    chk("reset.busy", 64'(busy), 64'h0);

    reset = 1'b1;
    step(1);
    experimenting = 1'b1;
    is_empty      = 16'h0000;
    wait_en(lat);
    chk("first.latency", 64'(lat), 64'd7);
    chk_slot("first", 4'hF, 8'hE4, 8'hE4, 4'hF);

    // Reset asserted mid-MATCH of the following slot
    step(13);
    chk("midmatch.busy", 64'(busy), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk_slot("async_rst", 4'h0, 8'h00, 8'h00, 4'h0);
    chk("async_rst.busy", 64'(busy), 64'h0);
    step(2);
    reset = 1'b1;
    wait_en(lat);
    chk("post_rst.latency", 64'(lat), 64'd7);
    chk_slot("post_rst", 4'hF, 8'hE4, 8'hE4, 4'hF);

    prev_val = 4'hF;
    for (int k = 0; k < 12; k++) begin
      is_empty = tbl[k].empty;
      step(1);
      chk($sformatf("row%0d.pulse", k), 64'(sched_en), 64'h0);
      chk($sformatf("row%0d.hold", k), 64'(xbar_valid), 64'(prev_val));
      step(15);
      chk_slot($sformatf("row%0d", k), tbl[k].en, tbl[k].ssel, tbl[k].xsel, tbl[k].xval);
      prev_val = tbl[k].xval;
    end

    // Run enable dropped during WAIT; pointers must survive
    step(1);
    experimenting = 1'b0;
    step(1);
    chk("drop.xbar_valid", 64'(xbar_valid), 64'h0);
    chk("drop.sched_en", 64'(sched_en), 64'h0);
    chk("drop.busy", 64'(busy), 64'h0);
    step(3);
    chk("idle.busy", 64'(busy), 64'h0);
    experimenting = 1'b1;
    is_empty      = 16'h0000;
    wait_en(lat);
    chk("resume.latency", 64'(lat), 64'd7);
    chk_slot("resume", 4'hF, 8'h87, 8'h36, 4'hF);

`ifdef SCHED_STATS_EN
    chk("stats.one", grant_cnt, {4{16'd1}});
    experimenting = 1'b0;
    step(2);
    experimenting = 1'b1;
    step(1);
    chk("stats.clear", grant_cnt, 64'h0);
    step(6 + 19 * 16);
    chk("stats.twenty", grant_cnt, {4{16'd20}});
    experimenting = 1'b0;
    step(1);
    experimenting = 1'b1;
    step(1);
    chk("stats.toggle", grant_cnt, 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
